// File: rtl/udp_tx_scheduler.sv
// Round-robin scheduler sharing one UDP transmit core between two frame sources.
// Grants a source, programs UDP/IP lengths, pulses tx_start, streams payload words
// on the core's word requests, and enforces an inter-frame gap and a frame timeout.
module udp_tx_scheduler #(
    parameter int unsigned IFG_CYCLES     = 16,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [3:0]  TX_IDLE_STATE  = 4'd0,
    parameter int unsigned MAX_PAYLOAD    = 1472
) (
    input  logic        e_rxc,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [15:0] len0,
    input  logic [15:0] len1,
    output logic [1:0]  gnt,
    output logic [1:0]  rd_en,
    input  logic [31:0] rd_data0,
    input  logic [31:0] rd_data1,
    output logic [1:0]  done,
    output logic        tx_start,
    input  logic        tx_data_req,
    output logic [31:0] tx_data,
    output logic [15:0] tx_data_length,
    output logic [15:0] tx_total_length,
    input  logic [3:0]  tx_state,
    output logic        err_len,
    output logic        err_timeout,
    output logic [15:0] frame_cnt
);

    typedef enum logic [2:0] {StIdle, StStart, StSend, StWaitDone, StGap} state_t;

    state_t      state_q, state_d;
    logic        ptr_q, ptr_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [13:0] words_q, words_d;
    logic        seen_busy_q, seen_busy_d;
    logic [31:0] tmo_q, tmo_d;
    logic [31:0] gap_q, gap_d;
    logic [1:0]  done_q, done_d;
    logic        err_len_q, err_len_d;
    logic        err_tmo_q, err_tmo_d;
    logic        start_q, start_d;
    logic [15:0] dlen_q, dlen_d;
    logic [15:0] tlen_q, tlen_d;
    logic [15:0] fcnt_q, fcnt_d;

    logic [1:0]  req_eff;
    logic        win;
    logic [15:0] win_len;
    logic        len_ok;
    logic        in_frame;

    // Arbitration: a source whose done is pulsing is masked so a held req is not re-served.
    always_comb begin
        req_eff = req & ~done_q;
        win     = req_eff[ptr_q] ? ptr_q : ~ptr_q;
        win_len = win ? len1 : len0;
        len_ok  = (win_len[1:0] == 2'b00) && (win_len >= 16'd4) &&
                  (win_len <= 16'(MAX_PAYLOAD));
    end

    // Word strobe and payload mux toward the UDP core.
    always_comb begin
        rd_en = 2'b00;
        if (state_q == StSend && tx_data_req && words_q != 14'd0) begin
            rd_en = gnt_q;
        end
        case (gnt_q)
            2'b01:   tx_data = rd_data0;
            2'b10:   tx_data = rd_data1;
            default: tx_data = 32'd0;
        endcase
    end

    // Next-state logic; the timeout overrides whatever the frame FSM decided.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        words_d     = words_q;
        seen_busy_d = seen_busy_q;
        tmo_d       = tmo_q;
        gap_d       = gap_q;
        done_d      = 2'b00;
        err_len_d   = 1'b0;
        err_tmo_d   = 1'b0;
        start_d     = 1'b0;
        dlen_d      = dlen_q;
        tlen_d      = tlen_q;
        fcnt_d      = fcnt_q;
        in_frame    = (state_q == StStart) || (state_q == StSend) || (state_q == StWaitDone);

        if (in_frame) begin
            tmo_d = tmo_q + 32'd1;
        end
        if ((state_q == StStart || state_q == StSend) && tx_state != TX_IDLE_STATE) begin
            seen_busy_d = 1'b1;
        end

        case (state_q)
            StIdle: begin
                if (|req_eff) begin
                    if (len_ok) begin
                        gnt_d       = win ? 2'b10 : 2'b01;
                        words_d     = win_len[15:2];
                        dlen_d      = win_len + 16'd8;
                        tlen_d      = win_len + 16'd28;
                        seen_busy_d = 1'b0;
                        tmo_d       = 32'd0;
                        state_d     = StStart;
                    end else begin
                        done_d    = win ? 2'b10 : 2'b01;
                        err_len_d = 1'b1;
                        ptr_d     = ~win;
                    end
                end
            end
            StStart: begin
                start_d = 1'b1;
                state_d = StSend;
            end
            StSend: begin
                if (rd_en != 2'b00) begin
                    words_d = words_q - 14'd1;
                end
                if (words_q == 14'd0 && (seen_busy_q || tx_state != TX_IDLE_STATE)) begin
                    state_d = StWaitDone;
                end
            end
            StWaitDone: begin
                if (tx_state == TX_IDLE_STATE) begin
                    done_d  = gnt_q;
                    fcnt_d  = fcnt_q + 16'd1;
                    ptr_d   = gnt_q[0];
                    gnt_d   = 2'b00;
                    gap_d   = 32'd0;
                    state_d = StGap;
                end
            end
            StGap: begin
                gap_d = gap_q + 32'd1;
                if (gap_q + 32'd1 >= IFG_CYCLES) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if (in_frame && tmo_q == TIMEOUT_CYCLES) begin
            err_tmo_d = 1'b1;
            done_d    = gnt_q;
            fcnt_d    = fcnt_q;
            ptr_d     = gnt_q[0];
            gnt_d     = 2'b00;
            gap_d     = 32'd0;
            start_d   = 1'b0;
            state_d   = StGap;
        end
    end

    // State and output registers.
    always_ff @(posedge e_rxc or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ptr_q       <= 1'b0;
            gnt_q       <= 2'b00;
            words_q     <= 14'd0;
            seen_busy_q <= 1'b0;
            tmo_q       <= 32'd0;
            gap_q       <= 32'd0;
            done_q      <= 2'b00;
            err_len_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            start_q     <= 1'b0;
            dlen_q      <= 16'd0;
            tlen_q      <= 16'd0;
            fcnt_q      <= 16'd0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            words_q     <= words_d;
            seen_busy_q <= seen_busy_d;
            tmo_q       <= tmo_d;
            gap_q       <= gap_d;
            done_q      <= done_d;
            err_len_q   <= err_len_d;
            err_tmo_q   <= err_tmo_d;
            start_q     <= start_d;
            dlen_q      <= dlen_d;
            tlen_q      <= tlen_d;
            fcnt_q      <= fcnt_d;
        end
    end

    // Registered outputs.
    always_comb begin
        gnt             = gnt_q;
        done            = done_q;
        tx_start        = start_q;
        tx_data_length  = dlen_q;
        tx_total_length = tlen_q;
        err_len         = err_len_q;
        err_timeout     = err_tmo_q;
        frame_cnt       = fcnt_q;
    end

endmodule

// File: tb/tb_udp_tx_scheduler.sv
// Randomised bench for udp_tx_scheduler: a procedural UDP-core/source model drives
// frames; expectations come from length rules, a round-robin pointer and a frame count.
module tb_udp_tx_scheduler;

    localparam int IFG     = 16;
    localparam int TMO     = 1000;
    localparam int MAX_PAY = 1472;

    logic        e_rxc;
    logic        rst;
    logic [1:0]  req;
    logic [15:0] len0, len1;
    logic [1:0]  gnt, rd_en, done;
    logic [31:0] rd_data0, rd_data1, tx_data;
    logic        tx_start, tx_data_req, err_len, err_timeout;
    logic [15:0] tx_data_length, tx_total_length, frame_cnt;
    logic [3:0]  tx_state;
    logic [88:0] all_outs;

    int n_checks = 0;
    int n_errors = 0;
    int ptr      = 0;   // model round-robin pointer
    int exp_cnt  = 0;   // model completed-frame count
    int zero_run = 0;
    int last_gap = 0;

    udp_tx_scheduler #(
        .IFG_CYCLES     (IFG),
        .TIMEOUT_CYCLES (TMO),
        .TX_IDLE_STATE  (4'd0),
        .MAX_PAYLOAD    (MAX_PAY)
    ) dut (
        .e_rxc           (e_rxc),
        .rst             (rst),
        .req             (req),
        .len0            (len0),
        .len1            (len1),
        .gnt             (gnt),
        .rd_en           (rd_en),
        .rd_data0        (rd_data0),
        .rd_data1        (rd_data1),
        .done            (done),
        .tx_start        (tx_start),
        .tx_data_req     (tx_data_req),
        .tx_data         (tx_data),
        .tx_data_length  (tx_data_length),
        .tx_total_length (tx_total_length),
        .tx_state        (tx_state),
        .err_len         (err_len),
        .err_timeout     (err_timeout),
        .frame_cnt       (frame_cnt)
    );

    assign all_outs = {gnt, rd_en, done, tx_start, tx_data, tx_data_length, tx_total_length,
                       err_len, err_timeout, frame_cnt};

    initial e_rxc = 1'b0;
    always #4 e_rxc = ~e_rxc;

    // Length of the most recent run of cycles without any grant.
    always @(negedge e_rxc) begin
        if (gnt == 2'b00) begin
            zero_run = zero_run + 1;
        end else if (zero_run != 0) begin
            last_gap = zero_run;
            zero_run = 0;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge e_rxc);
        #1;
    endtask

    // Waits for tx_start; lat is the number of rising edges after the last input change.
    task automatic wait_start(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge e_rxc);
            if (tx_start) begin
                lat = n - 1;
                break;
            end
        end
        if (lat < 0) check_eq("tx_start seen", 32'd0, 32'd1);
    endtask

    // Plays the UDP core for one granted frame, starting at the tx_start sample.
    task automatic serve(input int src, input int len, input int nreq, input bit hang);
        int   words, nrd, nother, bad, n, tail;
        bit   pend, got;
        logic [1:0] oh;
        words = len / 4;
        nrd = 0; nother = 0; bad = 0; n = 0; pend = 0; got = 0;
        oh = 2'(1 << src);
        tail = int'($urandom_range(1, 3));
        check_eq("grant", 32'(gnt), 32'(oh));
        check_eq("udp length", 32'(tx_data_length), 32'(len + 8));
        check_eq("ip length", 32'(tx_total_length), 32'(len + 28));
        for (int i = 0; i < nreq + tail; i++) begin
            step();
            if (src == 0) rd_data1 = $urandom; else rd_data0 = $urandom;
            if (pend) begin
                if (src == 0) rd_data0 = $urandom; else rd_data1 = $urandom;
            end
            pend = 0;
            tx_state = 4'd1;
            tx_data_req = (i < nreq);
            @(negedge e_rxc);
            n++;
            if (rd_en[src]) begin
                nrd++;
                pend = 1;
            end
            if (rd_en[1 - src]) nother++;
            if (tx_data !== (src == 1 ? rd_data1 : rd_data0)) bad++;
        end
        step();
        tx_data_req = 1'b0;
        if (!hang) tx_state = 4'd0;
        for (int k = 0; k < (hang ? TMO + 20 : 20) && !got; k++) begin
            @(negedge e_rxc);
            n++;
            if (done != 2'b00 || err_timeout) got = 1;
        end
        if (!hang) exp_cnt++;
        check_eq("done seen", 32'(got), 32'd1);
        check_eq("done", 32'(done), 32'(oh));
        check_eq("err_timeout", 32'(err_timeout), 32'(hang));
        check_eq("err_len in frame", 32'(err_len), 32'd0);
        check_eq("gnt released", 32'(gnt), 32'd0);
        if (hang) check_eq("timeout latency", 32'(n), 32'(TMO));
        check_eq("frame_cnt", 32'(frame_cnt), 32'(exp_cnt));
        check_eq("rd_en count", 32'(nrd), 32'(words));
        check_eq("rd_en other source", 32'(nother), 32'd0);
        check_eq("tx_data mux", 32'(bad), 32'd0);
        ptr = 1 - src;
    endtask

    // Idles past the gap; no stray done pulses and no payload may appear.
    task automatic idle_wait();
        int stray;
        stray = 0;
        repeat (IFG + 2) begin
            @(negedge e_rxc);
            if (done != 2'b00) stray++;
            step();
        end
        check_eq("stray done", 32'(stray), 32'd0);
        check_eq("idle tx_data", tx_data, 32'd0);
    endtask

    // One request from a single source; legality decided from the length rules.
    task automatic run_round(input int src, input int len, input int extra, input bit hang);
        int lat, n;
        bit legal, saw, got;
        legal = (len % 4 == 0) && (len >= 4) && (len <= MAX_PAY);
        step();
        if (src == 1) len1 = 16'(len); else len0 = 16'(len);
        req = 2'(1 << src);
        if (legal) begin
            wait_start(lat);
            check_eq("req to tx_start", 32'(lat), 32'd2);
            if (lat >= 0) serve(src, len, len / 4 + extra, hang);
        end else begin
            n = 0; saw = 0; got = 0;
            for (int k = 0; k < 6 && !got; k++) begin
                @(negedge e_rxc);
                n++;
                if (tx_start) saw = 1;
                if (done != 2'b00) got = 1;
            end
            check_eq("drop done", 32'(done), 32'(1 << src));
            check_eq("err_len", 32'(err_len), 32'd1);
            check_eq("drop latency", 32'(n - 1), 32'd1);
            check_eq("no tx_start on drop", 32'(saw), 32'd0);
            check_eq("frame_cnt after drop", 32'(frame_cnt), 32'(exp_cnt));
            ptr = 1 - src;
        end
        step();
        req = 2'b00;
        tx_state = 4'd0;
        idle_wait();
    endtask

    initial begin
        int lat, w, nrd, len, choice;
        bit saw_done;
        rst = 1'b1; req = 2'b00; len0 = 16'd0; len1 = 16'd0;
        rd_data0 = 32'd0; rd_data1 = 32'd0; tx_data_req = 1'b0; tx_state = 4'd0;
        repeat (3) @(posedge e_rxc);
        #1;
        check_eq("reset outputs zero", 32'(|all_outs), 32'd0);
        rst = 1'b0;
        repeat (2) step();

        run_round(0, 16, 0, 0);      // basic frame: 24 / 44, four words
        run_round(0, 16, 2, 0);      // core asks for two extra words
        run_round(1, 6, 0, 0);       // misaligned
        run_round(1, 1476, 0, 0);    // one word over the limit
        run_round(0, 16, 0, 0);      // source 0 still served
        run_round(0, 8, 0, 1);       // core never returns to idle
        run_round(1, 12, 1, 0);      // recovery after timeout
        run_round(1, 4, 0, 0);
        run_round(0, MAX_PAY, 1, 0);
        run_round(0, 0, 0, 0);

        for (int r = 0; r < 16; r++) begin
            choice = int'($urandom_range(0, 9));
            if (choice < 6) len = 4 * int'($urandom_range(1, 32));
            else if (choice < 8) len = 4 * int'($urandom_range(1, 32)) + int'($urandom_range(1, 3));
            else len = 1476 + 4 * int'($urandom_range(0, 8));
            run_round(int'($urandom_range(0, 1)), len, int'($urandom_range(0, 2)), 1'b0);
        end

        // Both sources hold requests; grants must alternate from the model pointer.
        step();
        len0 = 16'd8; len1 = 16'd8; req = 2'b11;
        for (int f = 0; f < 4; f++) begin
            w = ptr;
            wait_start(lat);
            if (lat < 0) break;
            if (f > 0) check_eq("inter-frame gap", 32'(last_gap >= IFG), 32'd1);
            serve(w, 8, 2, 1'b0);
            step();
            req[w] = 1'b0;
            step();
            req[w] = 1'b1;
        end
        step();
        req = 2'b00;
        idle_wait();

        // Reset while the third word is being fetched.
        step();
        len0 = 16'd16; req = 2'b01;
        wait_start(lat);
        nrd = 0;
        for (int i = 0; i < 2; i++) begin
            step();
            tx_state = 4'd1;
            tx_data_req = 1'b1;
            @(negedge e_rxc);
            if (rd_en[0]) nrd++;
        end
        check_eq("words before reset", 32'(nrd), 32'd2);
        step();
        rst = 1'b1;
        #1;
        check_eq("mid-frame reset outputs zero", 32'(|all_outs), 32'd0);
        req = 2'b00; tx_data_req = 1'b0; tx_state = 4'd0;
        saw_done = 0;
        repeat (3) begin
            @(negedge e_rxc);
            if (done != 2'b00) saw_done = 1;
        end
        check_eq("no done on reset", 32'(saw_done), 32'd0);
        step();
        rst = 1'b0;
        ptr = 0;
        exp_cnt = 0;
        repeat (2) step();
        len0 = 16'd16; len1 = 16'd16; req = 2'b11;
        wait_start(lat);
        check_eq("restart latency", 32'(lat), 32'd2);
        if (lat >= 0) serve(0, 16, 4, 1'b0);
        step();
        req = 2'b00;
        idle_wait();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
